// File: rtl/multdiv_stall_unit.sv
// Iterative signed 32-bit multiply/divide beside the X-stage ALU; stalls the front of the pipe while busy.
// Optional DIV0_FAST_EN: divide-by-zero and MIN/-1 finish in one cycle instead of running all iterations.
module multdiv_stall_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       dx_writeReg,
  output logic             md_stall,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [4:0]       md_writeReg,
  output logic             md_writeEnable
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [4:0]       RSTATUS_REG    = 5'd30;
  localparam logic [WIDTH-1:0] MULT_OVF_CODE  = WIDTH'(4);
  localparam logic [WIDTH-1:0] DIV_FAULT_CODE = WIDTH'(5);
  localparam logic [WIDTH-1:0] MIN_NEG        = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT       = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, lo, opnd;
  logic             sign_q, mult_q, fault_q;
  logic [4:0]       rd_q;

  logic             start_c, fault_c, accept, load_out;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum, rem_shift, diff;
  logic [WIDTH-1:0] acc_step, lo_step, quot;
  logic [PW-1:0]    prod_mag, prod;
  logic [WIDTH:0]   hi_bits;
  logic             ovf;
  logic [WIDTH-1:0] fin_result;
  logic             fin_exc;
  logic [4:0]       fin_tag;

  assign start_c = ctrl_MULT | ctrl_DIV;
  assign fault_c = (data_operandB == '0) |
                   ((data_operandA == MIN_NEG) & (data_operandB == {WIDTH{1'b1}}));
  assign abs_a   = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
  assign abs_b   = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state, stall and output-load strobes
  always_comb begin
    state_next = state;
    md_stall   = 1'b0;
    accept     = 1'b0;
    load_out   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_c) begin
          md_stall = 1'b1;
          accept   = 1'b1;
`ifdef DIV0_FAST_EN
          if (!ctrl_MULT && fault_c) begin
            state_next = S_DONE;
            load_out   = 1'b1;
          end else begin
            state_next = S_RUN;
          end
`else
          state_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        md_stall = 1'b1;
        if (cnt == LAST_CNT) begin
          state_next = S_DONE;
          load_out   = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One shift-add (mult) or restoring shift-subtract (div) iteration
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
    rem_shift = {acc, lo[WIDTH-1]};
    diff      = rem_shift - {1'b0, opnd};
    if (mult_q) begin
      acc_step = sum[WIDTH:1];
      lo_step  = {sum[0], lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_step = diff[WIDTH-1:0];
      lo_step  = {lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = rem_shift[WIDTH-1:0];
      lo_step  = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix and exception mapping of the final iteration's value
  always_comb begin
    prod_mag   = {acc_step, lo_step};
    prod       = sign_q ? PW'(-prod_mag) : prod_mag;
    hi_bits    = prod[PW-1:WIDTH-1];
    ovf        = !((&hi_bits) | ~(|hi_bits));
    quot       = sign_q ? WIDTH'(-lo_step) : lo_step;
    fin_result = '0;
    fin_exc    = 1'b0;
    if (state == S_IDLE) begin
      fin_result = DIV_FAULT_CODE;
      fin_exc    = 1'b1;
    end else if (mult_q) begin
      fin_exc    = ovf;
      fin_result = ovf ? MULT_OVF_CODE : prod[WIDTH-1:0];
    end else begin
      fin_exc    = fault_q;
      fin_result = fault_q ? DIV_FAULT_CODE : quot;
    end
    fin_tag = fin_exc ? RSTATUS_REG : rd_q;
  end

  // Operand latch and iteration datapath; multiplier/dividend live in lo
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      lo      <= '0;
      opnd    <= '0;
      sign_q  <= 1'b0;
      mult_q  <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= '0;
    end else if (accept) begin
      cnt     <= '0;
      acc     <= '0;
      lo      <= ctrl_MULT ? abs_b : abs_a;
      opnd    <= ctrl_MULT ? abs_a : abs_b;
      sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      mult_q  <= ctrl_MULT;
      fault_q <= fault_c;
      rd_q    <= dx_writeReg;
    end else if (state == S_RUN) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_step;
      lo  <= lo_step;
    end
  end

  // Result registers: loaded on entry to DONE, held otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      md_writeReg    <= '0;
      data_resultRDY <= 1'b0;
      md_writeEnable <= 1'b0;
    end else begin
      data_resultRDY <= load_out;
      md_writeEnable <= load_out;
      if (load_out) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
        md_writeReg    <= fin_tag;
      end
    end
  end

endmodule
